// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Instruction encodings presented by EX on the op bus.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: magnitude capture, one shift-add or restoring-divide
// step per strobe, and combinational sign fix-up of the final result.
import muldiv_pkg::*;

module muldiv_iter #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            load,
    input  logic            step,
    input  op_t             op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    // Upper half: partial product / partial remainder.
    // Lower half: remaining multiplier bits / dividend bits shifting into quotient.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   rs_raw;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              div_by_zero;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;

    // Operand magnitudes and the next accumulator value for one iteration.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        a_neg     = is_signed_op(op) & rs_data[XLEN-1];
        b_neg     = is_signed_op(op) & rt_data[XLEN-1];
        a_mag_in  = a_neg ? -rs_data : rs_data;
        b_mag_in  = b_neg ? -rt_data : rt_data;

        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_shift = acc[2*XLEN-1:XLEN-1];
        diff      = rem_shift - {1'b0, b_mag};

        acc_next  = acc;
        if (!is_div) begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end else if (diff[XLEN]) begin
            // Trial subtraction borrowed: restore and shift in a 0 quotient bit.
            acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    // Capture operands on load, advance one iteration per step.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            // NOTE: the accumulators are cleared on reset even though load overwrites them, so res_* never shows stale data after reset.
            acc         <= '0;
            b_mag       <= '0;
            rs_raw      <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
            acc         <= {{XLEN{1'b0}}, a_mag_in};
            b_mag       <= b_mag_in;
            rs_raw      <= rs_data;
            is_div      <= is_div_op(op);
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            div_by_zero <= is_div_op(op) && (rt_data == '0);
        end else if (step) begin
            acc <= acc_next;
        end
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (is_div) begin
            if (div_by_zero) begin
                res_hi = rs_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                res_lo = neg_q ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer with HI/LO registers: accepts MULT/MULTU/DIV/DIVU
// from EX, runs XLEN iterations, and stalls EX while busy if it needs the unit.
import muldiv_pkg::*;

module muldiv_sequencer #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mf_req,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [CW-1:0]   counter;
    logic            load;
    logic            step;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    // A squashed EX instruction never starts an op or advances one.
    assign load  = (state == IDLE) & start & ~flush;
    assign step  = (state == RUN) & ~flush;
    assign busy  = (state != IDLE);
    // Only instructions that need HI/LO or the unit are held; done cycle is IDLE so MFHI/MFLO see new values.
    assign stall = busy & (start | mf_req | mthi | mtlo);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .reset_b (reset_b),
        .load    (load),
        .step    (step),
        .op      (op_t'(op)),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
    );

    // Control FSM with registered HI/LO and done pulse; flush aborts without touching HI/LO.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= IDLE;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                        if (start) begin
                            counter <= CW'(XLEN - 1);
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (counter == '0) begin
                            state <= FINISH;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    FINISH: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk     = 1'b0;
    logic        reset_b = 1'b0;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mf_req  = 1'b0;
    logic        mthi    = 1'b0;
    logic        mtlo    = 1'b0;
    logic [31:0] wdata   = '0;
    logic        flush   = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] scoreboard[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mf_req  (mf_req),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .flush   (flush),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference {hi,lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sp;
        logic signed [31:0] qa;
        logic signed [31:0] qb;
        case (o)
            2'b00: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                sp = sa * sb;
                return sp;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qa = a;
                qb = b;
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drive one start cycle and queue its expected result; returns in cycle 1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        scoreboard.push_back(exp);
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency, busy span and popped result.
    task automatic wait_done(input string tag, input int lat0);
        int          lat;
        int          busy_cnt;
        logic [63:0] e;
        lat      = lat0;
        busy_cnt = 0;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(34 - lat0));
        check({tag, " busy in done cycle"}, 64'(busy), 64'd0);
        e = (scoreboard.size() > 0) ? scoreboard.pop_front() : 'x;
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] e;
        int          stall_bad;
        int          early_done;
        int          done_cnt;

        // Reset state
        @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        #2 reset_b = 1'b1;
        tick();

        // MULTU max operands, latency and one-cycle done
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_done("multu_max", 1);
        tick();
        @(negedge clk);
        check("done one cycle", 64'(done), 64'd0);
        tick();

        // Directed signed/unsigned cases and divide boundaries
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_done("mult_neg", 1);
        tick();
        start_op(2'b11, 32'd7, 32'd2, {32'd1, 32'd3});
        wait_done("divu_7_2", 1);
        tick();
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_done("div_m7_2", 1);
        tick();
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        wait_done("div_ovf", 1);
        tick();
        start_op(2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        wait_done("divu_by0", 1);
        tick();
        start_op(2'b10, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_done("div_neg_by0", 1);
        tick();

        // Stall from mf_req, ignored start during RUN, accepted in done cycle
        op      = 2'b01;
        rs_data = 32'd3;
        rt_data = 32'd5;
        start   = 1'b1;
        scoreboard.push_back({32'd0, 32'd15});
        tick();
        start      = 1'b0;
        stall_bad  = 0;
        early_done = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) mf_req = 1'b1;
            if (c == 10) begin
                op      = 2'b11;
                rs_data = 32'd100;
                rt_data = 32'd7;
                start   = 1'b1;
            end
            @(negedge clk);
            if (stall !== 1'(c >= 5)) stall_bad++;
            if (done) early_done++;
            tick();
        end
        check("stall cycles 1-33", 64'(stall_bad), 64'd0);
        check("no early done", 64'(early_done), 64'd0);
        @(negedge clk);
        check("first op done c34", 64'(done), 64'd1);
        check("stall in done cycle", 64'(stall), 64'd0);
        e = (scoreboard.size() > 0) ? scoreboard.pop_front() : 'x;
        check("first op hi", 64'(hi), 64'(e[63:32]));
        check("first op lo", 64'(lo), 64'(e[31:0]));
        scoreboard.push_back({32'd2, 32'd14});
        tick();
        start  = 1'b0;
        mf_req = 1'b0;
        wait_done("queued_divu", 1);
        tick();

        // MTHI in IDLE
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        mthi = 1'b0;
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo kept", 64'(lo), 64'd14);
        tick();

        // MTLO during RUN is stalled and lands once IDLE
        start_op(2'b01, 32'd2, 32'd3, {32'd0, 32'd6});
        mtlo  = 1'b1;
        wdata = 32'h0000_BEEF;
        @(negedge clk);
        check("mtlo stall", 64'(stall), 64'd1);
        check("mtlo lo held", 64'(lo), 64'd14);
        check("mtlo hi held", 64'(hi), 64'h1234);
        tick();
        wait_done("mtlo_op", 2);
        tick();
        mtlo = 1'b0;
        @(negedge clk);
        check("mtlo after idle lo", 64'(lo), 64'hBEEF);
        check("mtlo after idle hi", 64'(hi), 64'd0);
        tick();

        // Flush in cycle 10 aborts: no done, HI/LO unchanged
        op      = 2'b01;
        rs_data = 32'd9;
        rt_data = 32'd9;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush busy c11", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'd0);
        check("flush lo", 64'(lo), 64'hBEEF);
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush no done", 64'(done_cnt), 64'd0);
        tick();

        // Flush together with start in IDLE: not started
        op      = 2'b00;
        rs_data = 32'd4;
        rt_data = 32'd4;
        start   = 1'b1;
        flush   = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start busy", 64'(busy), 64'd0);
        tick();

        // Pseudo-random operations against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 2) rb = $urandom_range(1, 9);
            if (i == 4) ro = 2'b10;
            start_op(ro, ra, rb, model(ro, ra, rb));
            wait_done("random", 1);
            tick();
        end
        check("scoreboard drained", 64'(scoreboard.size()), 64'd0);

        // Asynchronous reset mid-RUN
        op      = 2'b01;
        rs_data = 32'h0001_2345;
        rt_data = 32'h0000_0678;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        mf_req = 1'b1;
        #1;
        check("pre-reset stall", 64'(stall), 64'd1);
        reset_b = 1'b0;
        #1;
        check("mid reset hi", 64'(hi), 64'd0);
        check("mid reset lo", 64'(lo), 64'd0);
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset stall", 64'(stall), 64'd0);
        #4;
        mf_req  = 1'b0;
        reset_b = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
